// File: rtl/gpr_mp_pkg.sv
// Shared definitions for the multi-port GPR file: default geometry,
// active-low enable levels and clear-engine state encodings.
package gpr_mp_pkg;

   localparam int GPR_DATA_W  = 32;
   localparam int GPR_ADDR_W  = 5;
   localparam int GPR_REG_NUM = 32;

   localparam logic ENABLE_N  = 1'b0;
   localparam logic DISABLE_N = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

   // Range check kept as a function so the comparison width follows the caller.
   function automatic logic addr_ok(input int unsigned a, input int unsigned n);
      return a < n;
   endfunction

endpackage

// File: rtl/gpr_mp_clr_fsm.sv
// Bulk-clear sequencer: walks an address counter over every register,
// then raises a one-cycle done pulse before returning to idle.
module gpr_clr_fsm
   import gpr_mp_pkg::*;
#(
   parameter int ADDR_W  = GPR_ADDR_W,
   parameter int REG_NUM = GPR_REG_NUM
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr_req,
   output logic              o_clr_busy,
   output logic              o_clr_done,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr,
   output clr_state_e        o_state
);

   clr_state_e        r_state;
   clr_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_clr_we    = 1'b0;
      o_clr_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            o_clr_we  = 1'b1;
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            if (r_cnt == ADDR_W'(REG_NUM - 1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_clr_done  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_clr_busy = (r_state != ST_IDLE);
   assign o_clr_addr = r_cnt;
   assign o_state    = r_state;

endmodule

// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file with scoreboard busy bits,
// two retire write lanes (lane 1 has priority) and a sequenced bulk clear.
module gpr_mp
   import gpr_mp_pkg::*;
#(
   parameter int DATA_W   = GPR_DATA_W,
   parameter int ADDR_W   = GPR_ADDR_W,
   parameter int REG_NUM  = GPR_REG_NUM,
   parameter int RD_PORTS = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
   output logic [RD_PORTS*DATA_W-1:0]   rd_data,
   output logic [RD_PORTS-1:0]          rd_busy,
   input  logic                         we0_n,
   input  logic [ADDR_W-1:0]            wr0_addr,
   input  logic [DATA_W-1:0]            wr0_data,
   input  logic                         we1_n,
   input  logic [ADDR_W-1:0]            wr1_addr,
   input  logic [DATA_W-1:0]            wr1_data,
   input  logic                         sb_set,
   input  logic [ADDR_W-1:0]            sb_addr,
   input  logic                         clr_req,
   output logic                         clr_busy,
   output logic                         clr_done,
   output clr_state_e                   o_dbg_clr_state
);

   logic [DATA_W-1:0]  r_regs [REG_NUM];
   logic [REG_NUM-1:0] r_busy;

   logic              w_clr_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_we0;
   logic              w_we1;
   logic              w_sb;

   gpr_clr_fsm #(
      .ADDR_W  (ADDR_W),
      .REG_NUM (REG_NUM)
   ) u_clr_fsm (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_clr_req  (clr_req),
      .o_clr_busy (w_clr_busy),
      .o_clr_done (clr_done),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr),
      .o_state    (o_dbg_clr_state)
   );

   assign clr_busy = w_clr_busy;

   // Qualified enables: dropped during clear, out of range, or aimed at a hardwired r0.
   assign w_we0 = (we0_n == ENABLE_N) && !w_clr_busy && addr_ok(32'(wr0_addr), REG_NUM)
                  && !((ZERO_REG != 0) && (wr0_addr == '0));
   assign w_we1 = (we1_n == ENABLE_N) && !w_clr_busy && addr_ok(32'(wr1_addr), REG_NUM)
                  && !((ZERO_REG != 0) && (wr1_addr == '0));
   assign w_sb  = sb_set && !w_clr_busy && addr_ok(32'(sb_addr), REG_NUM)
                  && !((ZERO_REG != 0) && (sb_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (w_clr_we && (w_clr_addr == ADDR_W'(i))) begin
               r_regs[i] <= '0;
               r_busy[i] <= 1'b0;
            end else begin
               if (w_we1 && (wr1_addr == ADDR_W'(i))) begin
                  r_regs[i] <= wr1_data;
               end else if (w_we0 && (wr0_addr == ADDR_W'(i))) begin
                  r_regs[i] <= wr0_data;
               end
               // A new producer issuing in the retire cycle keeps the register busy.
               if (w_sb && (sb_addr == ADDR_W'(i))) begin
                  r_busy[i] <= 1'b1;
               end else if ((w_we1 && (wr1_addr == ADDR_W'(i))) ||
                            (w_we0 && (wr0_addr == ADDR_W'(i)))) begin
                  r_busy[i] <= 1'b0;
               end
            end
         end
      end
   end

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_stored;
      logic              w_sbusy;
      logic              w_zero;
      logic              w_hit0;
      logic              w_hit1;

      assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         w_stored = '0;
         w_sbusy  = 1'b0;
         for (int i = 0; i < REG_NUM; i++) begin
            if (w_addr == ADDR_W'(i)) begin
               w_stored = r_regs[i];
               w_sbusy  = r_busy[i];
            end
         end
      end

      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit1 = (BYPASS != 0) && w_we1 && (wr1_addr == w_addr);
      assign w_hit0 = (BYPASS != 0) && w_we0 && (wr0_addr == w_addr);

      assign rd_data[k*DATA_W +: DATA_W] = w_zero ? '0       :
                                           w_hit1 ? wr1_data :
                                           w_hit0 ? wr0_data : w_stored;
      assign rd_busy[k] = !w_zero && !w_hit1 && !w_hit0 && w_sbusy;
   end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp: reset state, bypass, write priority, r0,
// scoreboard set/clear ordering and the bulk-clear sequence with mid-clear reset.
module tb_gpr_mp;
   import gpr_mp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        we0_n;
   logic [4:0]  wr0_addr;
   logic [31:0] wr0_data;
   logic        we1_n;
   logic [4:0]  wr1_addr;
   logic [31:0] wr1_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;
   clr_state_e  dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int n;
   int done_at;

   always #5 clk = ~clk;

   gpr_mp dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .rd_busy         (rd_busy),
      .we0_n           (we0_n),
      .wr0_addr        (wr0_addr),
      .wr0_data        (wr0_data),
      .we1_n           (we1_n),
      .wr1_addr        (wr1_addr),
      .wr1_data        (wr1_data),
      .sb_set          (sb_set),
      .sb_addr         (sb_addr),
      .clr_req         (clr_req),
      .clr_busy        (clr_busy),
      .clr_done        (clr_done),
      .o_dbg_clr_state (dbg_state)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0_n   = 1'b1;
      we1_n   = 1'b1;
      sb_set  = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      idle();
      wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; sb_addr = '0;
      set_rd(5'd0, 5'd0);
      rst_n = 1'b0;
      #12;
      chk("rst_clr_busy", 64'(clr_busy), 64'd0);
      chk("rst_clr_done", 64'(clr_done), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // Reset contents on both ports
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(31 - a));
         #1;
         chk("rst_rd_data", rd_data, 64'd0);
         chk("rst_rd_busy", 64'(rd_busy), 64'd0);
      end

      // Same-cycle bypass then stored value
      tick();
      we0_n = 1'b0; wr0_addr = 5'd5; wr0_data = 32'hA5A5_0001;
      set_rd(5'd5, 5'd5);
      #1;
      chk("byp_p0", 64'(rd_data[31:0]), 64'hA5A5_0001);
      chk("byp_p1", 64'(rd_data[63:32]), 64'hA5A5_0001);
      tick();
      idle();
      #1;
      chk("stored_r5", 64'(rd_data[31:0]), 64'hA5A5_0001);

      // Both lanes to r7: lane 1 wins
      tick();
      we0_n = 1'b0; wr0_addr = 5'd7; wr0_data = 32'h11;
      we1_n = 1'b0; wr1_addr = 5'd7; wr1_data = 32'h22;
      set_rd(5'd7, 5'd7);
      #1;
      chk("prio_byp", rd_data, {32'h22, 32'h22});
      tick();
      idle();
      #1;
      chk("prio_stored", rd_data, {32'h22, 32'h22});

      // r0 hardwired to zero
      tick();
      we0_n = 1'b0; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
      we1_n = 1'b0; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
      set_rd(5'd0, 5'd0);
      #1;
      chk("r0_byp", rd_data, 64'd0);
      tick();
      idle();
      sb_set = 1'b1; sb_addr = 5'd0;
      #1;
      chk("r0_stored", rd_data, 64'd0);
      tick();
      idle();
      #1;
      chk("r0_busy", 64'(rd_busy), 64'd0);

      // Scoreboard set / write ordering on r9
      sb_set = 1'b1; sb_addr = 5'd9;
      set_rd(5'd9, 5'd9);
      #1;
      chk("sb_pre", 64'(rd_busy), 64'd0);
      tick();
      sb_set = 1'b0;
      #1;
      chk("sb_set", 64'(rd_busy), 64'b11);
      we0_n = 1'b0; wr0_addr = 5'd9; wr0_data = 32'h99;
      sb_set = 1'b1; sb_addr = 5'd9;
      #1;
      chk("sb_wr_fwd_busy", 64'(rd_busy), 64'd0);
      chk("sb_wr_fwd_data", 64'(rd_data[31:0]), 64'h99);
      tick();
      idle();
      #1;
      chk("sb_set_wins", 64'(rd_busy), 64'b11);
      chk("sb_set_data", 64'(rd_data[63:32]), 64'h99);
      we1_n = 1'b0; wr1_addr = 5'd9; wr1_data = 32'h55;
      #1;
      chk("sb_wr_same_cyc", 64'(rd_busy), 64'd0);
      tick();
      idle();
      #1;
      chk("sb_wr_cleared", 64'(rd_busy), 64'd0);
      chk("sb_wr_data", 64'(rd_data[31:0]), 64'h55);

      // Fill every register, mark r3 busy
      for (int a = 1; a < 32; a++) begin
         we0_n = 1'b0; wr0_addr = 5'(a); wr0_data = 32'h1000_0000 | 32'(a);
         tick();
      end
      idle();
      sb_set = 1'b1; sb_addr = 5'd3;
      tick();
      idle();
      set_rd(5'd31, 5'd3);
      #1;
      chk("fill_r31", 64'(rd_data[31:0]), 64'h1000_001F);
      chk("fill_r3", 64'(rd_data[63:32]), 64'h1000_0003);
      chk("fill_r3_busy", 64'(rd_busy), 64'b10);

      // Bulk clear, request held for a few cycles
      clr_req = 1'b1;
      tick();
      n = 0;
      done_at = 0;
      while (clr_busy === 1'b1 && n < 100) begin
         n++;
         if (clr_done === 1'b1) done_at = n;
         clr_req = (n < 3);
         we0_n   = 1'b1;
         sb_set  = 1'b0;
         if (n == 5) begin
            we0_n = 1'b0; wr0_addr = 5'd31; wr0_data = 32'hDEAD;
            sb_set = 1'b1; sb_addr = 5'd31;
            set_rd(5'd31, 5'd2);
            #1;
            chk("clr_no_bypass", 64'(rd_data[31:0]), 64'h1000_001F);
            chk("clr_already_zero", 64'(rd_data[63:32]), 64'd0);
         end
         tick();
      end
      idle();
      chk("clr_busy_cycles", 64'(n), 64'd33);
      chk("clr_done_cycle", 64'(done_at), 64'd33);
      chk("clr_state_idle", 64'(dbg_state), 64'(ST_IDLE));
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(31 - a));
         #1;
         chk("post_clr_data", rd_data, 64'd0);
         chk("post_clr_busy", 64'(rd_busy), 64'd0);
      end

      // Reset in cycle 10 of a clear
      tick();
      we0_n = 1'b0; wr0_addr = 5'd20; wr0_data = 32'h20;
      tick();
      idle();
      set_rd(5'd20, 5'd20);
      #1;
      chk("pre_rst_r20", 64'(rd_data[31:0]), 64'h20);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (9) tick();
      chk("mid_clr_busy", 64'(clr_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(clr_busy), 64'd0);
      chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("mid_rst_r20", 64'(rd_data[31:0]), 64'd0);
      #3;
      rst_n = 1'b1;
      tick();
      chk("after_rst_done", 64'(clr_done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
